// File: rtl/uart_rxd_deser_if.sv
// ---------------------------------------------------------------------------
// uart_rxd_deser_if
//
// Write port of the receive FIFO that sits between the serial deserializer
// and uart_rxd_if. The deserializer is the master (it produces characters),
// the FIFO is the slave (it reports back when it cannot accept more).
//
// Signals:
//   rxd_fifo_wr     master -> slave  one-cycle write strobe
//   rxd_fifo_wdata  master -> slave  [7:0] data, [8] parity err, [9] frame err
//   rxd_fifo_wfull  slave -> master  FIFO full, write is suppressed
// ---------------------------------------------------------------------------
interface uart_rxd_deser_if;

   logic       rxd_fifo_wr;
   logic [9:0] rxd_fifo_wdata;
   logic       rxd_fifo_wfull;

   modport master (
      output rxd_fifo_wr,
      output rxd_fifo_wdata,
      input  rxd_fifo_wfull
   );

   modport slave (
      input  rxd_fifo_wr,
      input  rxd_fifo_wdata,
      output rxd_fifo_wfull
   );

endinterface : uart_rxd_deser_if

// File: rtl/uart_rxd_deser.sv
// ---------------------------------------------------------------------------
// uart_rxd_deser
//
// Serial front end of the UART receive path. The asynchronous rxd line is
// synchronised, oversampled 16x per bit and framed into start / 8 data /
// optional parity / stop. Each completed character is pushed, together with
// its parity and frame error flags, into the receive FIFO.
//
// Parameters:
//   BAUD_DIV      i_clk cycles per oversample tick (bit = 16*BAUD_DIV clocks)
//
// Ports:
//   i_clk          UART-domain clock
//   i_rst          asynchronous active-low reset
//   i_rxd          asynchronous serial input, idle high
//   i_parity_en    1 = a parity bit follows the data bits
//   i_parity_odd   1 = odd parity, 0 = even (ignored without parity)
//   fifo           FIFO write port (master side): strobe, data, full
//   o_busy         high while a frame is being received
//   o_overrun      one-cycle pulse when a finished character is dropped
// ---------------------------------------------------------------------------
module uart_rxd_deser #(
   parameter int BAUD_DIV = 27
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_rxd,
   input  logic             i_parity_en,
   input  logic             i_parity_odd,
   uart_rxd_deser_if.master fifo,
   output logic             o_busy,
   output logic             o_overrun
);

   // Oversampling ratio is tied to the 4-bit sample counter width.
   localparam int OVERSAMPLE = 16;
   localparam int SMP_W      = $clog2(OVERSAMPLE);
   localparam int DIV_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);

   // The counter value is checked before it advances, so the tick seen with
   // count 6 is the one that reaches sample 7, and so on. This puts the
   // decision exactly 9 ticks into each bit.
   localparam logic [SMP_W-1:0] SMP_VOTE_A = SMP_W'(6);
   localparam logic [SMP_W-1:0] SMP_VOTE_B = SMP_W'(7);
   localparam logic [SMP_W-1:0] SMP_DECIDE = SMP_W'(8);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_e;

   // ------------------------------------------------------------------------
   // Input synchroniser and falling-edge detector.
   // rxd_prev_q is a third stage used only to find the 1->0 transition, so a
   // line that is already low when IDLE is entered never starts a frame.
   // ------------------------------------------------------------------------
   logic rxd_meta_q;
   logic rxd_s_q;
   logic rxd_prev_q;
   logic rxd_fall;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         // Reset to the idle (mark) level so release of reset is not an edge.
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments here make each flop capture the
         // previous stage's old value, which is what builds the shift chain.
         rxd_meta_q <= i_rxd;
         rxd_s_q    <= rxd_meta_q;
         rxd_prev_q <= rxd_s_q;
      end
   end

   assign rxd_fall = rxd_prev_q & ~rxd_s_q;

   // ------------------------------------------------------------------------
   // Tick generator and sample counter.
   // Both are held at zero in IDLE, so they start from zero on START entry.
   // ------------------------------------------------------------------------
   state_e           state_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic [SMP_W-1:0] smp_q;
   logic [SMP_W-1:0] smp_d;
   logic             tick;

   assign tick = (div_q == DIV_LAST);

   always_comb begin
      // NOTE: defaulting every output first keeps this block free of latches
      // on paths that do not assign it.
      div_d = div_q;
      smp_d = smp_q;
      if (state_q == ST_IDLE) begin
         div_d = '0;
         smp_d = '0;
      end else if (tick) begin
         div_d = '0;
         smp_d = smp_q + SMP_W'(1);
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         div_q <= '0;
         smp_q <= '0;
      end else begin
         div_q <= div_d;
         smp_q <= smp_d;
      end
   end

   // ------------------------------------------------------------------------
   // Majority vote over samples 7, 8 and 9. The first two samples are held,
   // the third is the live synchronised line at the decision tick.
   // ------------------------------------------------------------------------
   logic vote_a_q;
   logic vote_b_q;
   logic decide;
   logic bit_val;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         vote_a_q <= 1'b1;
         vote_b_q <= 1'b1;
      end else begin
         if (tick && smp_q == SMP_VOTE_A) vote_a_q <= rxd_s_q;
         if (tick && smp_q == SMP_VOTE_B) vote_b_q <= rxd_s_q;
      end
   end

   assign decide  = tick && (smp_q == SMP_DECIDE);
   assign bit_val = (vote_a_q & vote_b_q) | (vote_a_q & rxd_s_q) | (vote_b_q & rxd_s_q);

   // ------------------------------------------------------------------------
   // Frame FSM with registered outputs.
   // Parity configuration is captured at START entry so a reconfiguration
   // mid-frame cannot change the frame length or the parity sense.
   // ------------------------------------------------------------------------
   logic [7:0] shift_q;
   logic [2:0] bit_cnt_q;
   logic       par_en_q;
   logic       par_odd_q;
   logic       perr_q;
   logic       wr_q;
   logic [9:0] wdata_q;
   logic       busy_q;
   logic       overrun_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q   <= ST_IDLE;
         // NOTE: the shift register is a plain register, not a memory, so it
         // is reset along with the rest; a reset mid-frame leaves nothing
         // stale behind.
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_en_q  <= 1'b0;
         par_odd_q <= 1'b0;
         perr_q    <= 1'b0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-armed below.
         wr_q      <= 1'b0;
         overrun_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (rxd_fall) begin
                  state_q   <= ST_START;
                  busy_q    <= 1'b1;
                  par_en_q  <= i_parity_en;
                  par_odd_q <= i_parity_odd;
                  perr_q    <= 1'b0;
                  bit_cnt_q <= '0;
               end
            end

            ST_START: begin
               if (decide) begin
                  if (bit_val) begin
                     // Line was high again at mid-bit: a glitch, not a start.
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DATA;
                  end
               end
            end

            ST_DATA: begin
               if (decide) begin
                  // LSB arrives first, so shift in from the top.
                  shift_q   <= {bit_val, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= par_en_q ? ST_PARITY : ST_STOP;
                  end
               end
            end

            ST_PARITY: begin
               if (decide) begin
                  perr_q  <= (bit_val != ((^shift_q) ^ par_odd_q));
                  state_q <= ST_STOP;
               end
            end

            ST_STOP: begin
               if (decide) begin
                  // Return to IDLE at mid stop bit so the next start edge
                  // can be caught even when frames are back-to-back.
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  if (fifo.rxd_fifo_wfull) begin
                     overrun_q <= 1'b1;
                  end else begin
                     wr_q    <= 1'b1;
                     wdata_q <= {~bit_val, perr_q, shift_q};
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo.rxd_fifo_wr    = wr_q;
   assign fifo.rxd_fifo_wdata = wdata_q;
   assign o_busy              = busy_q;
   assign o_overrun           = overrun_q;

endmodule : uart_rxd_deser

// File: tb/tb_uart_rxd_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rxd_deser
//
// Drives serial frames into uart_rxd_deser at BAUD_DIV=2 (32 clocks per bit)
// and compares the FIFO writes, overrun pulses and busy flag against values
// derived from the UART framing rules.
// ---------------------------------------------------------------------------
module tb_uart_rxd_deser;

   localparam int BAUD_DIV = 2;
   localparam int BIT_CLKS = 16 * BAUD_DIV;

   logic clk;
   logic i_rst;
   logic i_rxd;
   logic i_parity_en;
   logic i_parity_odd;
   logic o_busy;
   logic o_overrun;

   uart_rxd_deser_if fifo_if ();

   uart_rxd_deser #(
      .BAUD_DIV (BAUD_DIV)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_rxd        (i_rxd),
      .i_parity_en  (i_parity_en),
      .i_parity_odd (i_parity_odd),
      .fifo         (fifo_if.master),
      .o_busy       (o_busy),
      .o_overrun    (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Observed FIFO writes, overrun pulses and busy cycles, sampled on the
   // falling edge, away from the DUT's active edge.
   logic [9:0] wq[$];
   int         ovr_cnt  = 0;
   int         busy_cnt = 0;

   always @(negedge clk) begin
      if (fifo_if.rxd_fifo_wr === 1'b1) wq.push_back(fifo_if.rxd_fifo_wdata);
      if (o_overrun === 1'b1) ovr_cnt++;
      if (o_busy === 1'b1) busy_cnt++;
   end

   // Expected FIFO word from the framing rules: the parity error is set when
   // the count of ones over data plus parity bit does not have the configured
   // sense; the frame error is set when the stop bit is not a mark.
   function automatic logic [9:0] model_word(input logic [7:0] d, input bit pe,
                                             input bit odd, input logic pbit,
                                             input logic stop);
      int  ones;
      bit  perr;
      ones = $countones(d) + int'(pbit);
      perr = pe && ((ones % 2) != int'(odd));
      return {~stop, perr, d};
   endfunction

   // Sends one frame. glitch_bit inverts the line for one clock inside that
   // frame bit (0 = start, k+1 = data bit k); abort_bit returns mid-way
   // through that frame bit; scramble changes the parity configuration
   // once the start bit has been sent.
   task automatic send_frame(input logic [7:0] data, input bit pe, input bit odd,
                             input logic pbit, input logic stop,
                             input int glitch_bit, input int abort_bit,
                             input bit scramble);
      logic fb [0:10];
      int   n;
      i_parity_en  = pe;
      i_parity_odd = odd;
      for (int i = 0; i < 11; i++) fb[i] = 1'b1;
      fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) fb[i+1] = data[i];
      n = 9;
      if (pe) begin
         fb[n] = pbit;
         n++;
      end
      fb[n] = stop;
      n++;
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < BIT_CLKS; c++) begin
            if (b == abort_bit && c == BIT_CLKS / 2) return;
            i_rxd = (b == glitch_bit && c == 19) ? ~fb[b] : fb[b];
            @(negedge clk);
         end
         if (b == 0 && scramble) begin
            i_parity_en  = 1'($urandom_range(0, 1));
            i_parity_odd = 1'($urandom_range(0, 1));
         end
      end
      i_rxd = 1'b1;
   endtask

   task automatic idle_line(input int n);
      i_rxd = 1'b1;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [9:0] got;
      i_rst = 1'b0;
      i_rxd = 1'b1;
      i_parity_en = 1'b0;
      i_parity_odd = 1'b0;
      fifo_if.rxd_fifo_wfull = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (fifo_if.rxd_fifo_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", fifo_if.rxd_fifo_wr);
      else n_pass++;
      got = fifo_if.rxd_fifo_wdata;
      n_checks++;
      if (got !== 10'h000) $display("FAIL reset_wdata: got %h want 000", got);
      else n_pass++;
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy);
      else n_pass++;
      n_checks++;
      if (o_overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", o_overrun);
      else n_pass++;
      i_rst = 1'b1;
      idle_line(16);
      n_checks++;
      if (wq.size() !== 0) $display("FAIL reset_release_writes: got %0d want 0", wq.size());
      else n_pass++;
   endtask

   task automatic test_basic;
      logic [9:0] got;
      wq.delete();
      busy_cnt = 0;
      send_frame(8'h93, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      idle_line(16);
      got = (wq.size() > 0) ? wq[0] : 10'hxxx;
      n_checks++;
      if (wq.size() !== 1) $display("FAIL basic_count: got %0d want 1", wq.size());
      else n_pass++;
      n_checks++;
      if (got !== 10'h093) $display("FAIL basic_wdata: got %h want 093", got);
      else n_pass++;
      // Busy spans from just after the start edge to mid stop bit: ~9.5 bits.
      n_checks++;
      if (busy_cnt < 9 * BIT_CLKS + 8 || busy_cnt > 9 * BIT_CLKS + 28)
         $display("FAIL basic_busy_len: got %0d cycles want about %0d", busy_cnt, 9 * BIT_CLKS + 18);
      else n_pass++;
   endtask

   task automatic test_parity;
      logic       pb  [3] = '{1'b0, 1'b1, 1'b1};
      bit         odd [3] = '{1'b0, 1'b0, 1'b1};
      logic [9:0] exp [3] = '{10'h093, 10'h193, 10'h093};
      logic [9:0] got;
      for (int i = 0; i < 3; i++) begin
         wq.delete();
         send_frame(8'h93, 1'b1, odd[i], pb[i], 1'b1, -1, -1, 1'b0);
         idle_line(16);
         got = (wq.size() > 0) ? wq[0] : 10'hxxx;
         n_checks++;
         if (wq.size() !== 1) $display("FAIL parity%0d_count: got %0d want 1", i, wq.size());
         else n_pass++;
         n_checks++;
         if (got !== exp[i]) $display("FAIL parity%0d_wdata: got %h want %h", i, got, exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_frame_error;
      logic [9:0] got;
      wq.delete();
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b0);
      // Break: line stays low for 30 bit times.
      i_rxd = 1'b0;
      repeat (30 * BIT_CLKS) @(negedge clk);
      #1;
      got = (wq.size() > 0) ? wq[0] : 10'hxxx;
      n_checks++;
      if (wq.size() !== 1) $display("FAIL ferr_count: got %0d want 1", wq.size());
      else n_pass++;
      n_checks++;
      if (got !== 10'h25A) $display("FAIL ferr_wdata: got %h want 25a", got);
      else n_pass++;
      idle_line(BIT_CLKS);
      wq.delete();
      send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      idle_line(16);
      got = (wq.size() > 0) ? wq[0] : 10'hxxx;
      n_checks++;
      if (wq.size() !== 1) $display("FAIL after_break_count: got %0d want 1", wq.size());
      else n_pass++;
      n_checks++;
      if (got !== 10'h001) $display("FAIL after_break_wdata: got %h want 001", got);
      else n_pass++;
   endtask

   task automatic test_false_start;
      wq.delete();
      busy_cnt = 0;
      i_rxd = 1'b0;
      repeat (8) @(negedge clk);
      i_rxd = 1'b1;
      repeat (BIT_CLKS) @(negedge clk);
      #1;
      n_checks++;
      if (busy_cnt < 1 || busy_cnt > BIT_CLKS)
         $display("FAIL false_start_busy_len: got %0d cycles want 1..%0d", busy_cnt, BIT_CLKS);
      else n_pass++;
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL false_start_busy: got %b want 0", o_busy);
      else n_pass++;
      n_checks++;
      if (wq.size() !== 0) $display("FAIL false_start_writes: got %0d want 0", wq.size());
      else n_pass++;
   endtask

   task automatic test_glitch;
      logic [9:0] got;
      wq.delete();
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1, 1'b0);
      idle_line(16);
      got = (wq.size() > 0) ? wq[0] : 10'hxxx;
      n_checks++;
      if (wq.size() !== 1) $display("FAIL glitch_count: got %0d want 1", wq.size());
      else n_pass++;
      n_checks++;
      if (got !== 10'h0FF) $display("FAIL glitch_wdata: got %h want 0ff", got);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      logic [9:0] got;
      wq.delete();
      ovr_cnt = 0;
      fifo_if.rxd_fifo_wfull = 1'b1;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      #1;
      // A dropped character must not disturb the held write data.
      got = fifo_if.rxd_fifo_wdata;
      n_checks++;
      if (got !== 10'h0FF) $display("FAIL overrun_hold_wdata: got %h want 0ff", got);
      else n_pass++;
      fifo_if.rxd_fifo_wfull = 1'b0;
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      idle_line(16);
      n_checks++;
      if (ovr_cnt !== 1) $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt);
      else n_pass++;
      got = (wq.size() > 0) ? wq[0] : 10'hxxx;
      n_checks++;
      if (wq.size() !== 1) $display("FAIL b2b_count: got %0d want 1", wq.size());
      else n_pass++;
      n_checks++;
      if (got !== 10'h0C3) $display("FAIL b2b_wdata: got %h want 0c3", got);
      else n_pass++;
   endtask

   task automatic test_reset_midframe;
      logic [9:0] got;
      wq.delete();
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 5, 1'b0);
      i_rst = 1'b0;
      #1;
      n_checks++;
      if (fifo_if.rxd_fifo_wr !== 1'b0) $display("FAIL midreset_wr: got %b want 0", fifo_if.rxd_fifo_wr);
      else n_pass++;
      got = fifo_if.rxd_fifo_wdata;
      n_checks++;
      if (got !== 10'h000) $display("FAIL midreset_wdata: got %h want 000", got);
      else n_pass++;
      n_checks++;
      if (o_busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", o_busy);
      else n_pass++;
      i_rxd = 1'b1;
      repeat (4) @(negedge clk);
      i_rst = 1'b1;
      idle_line(3 * BIT_CLKS / 2);
      n_checks++;
      if (wq.size() !== 0) $display("FAIL midreset_stale_write: got %0d want 0", wq.size());
      else n_pass++;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0);
      idle_line(16);
      got = (wq.size() > 0) ? wq[0] : 10'hxxx;
      n_checks++;
      if (wq.size() !== 1) $display("FAIL midreset_after_count: got %0d want 1", wq.size());
      else n_pass++;
      n_checks++;
      if (got !== 10'h0A5) $display("FAIL midreset_after_wdata: got %h want 0a5", got);
      else n_pass++;
   endtask

   task automatic test_random;
      logic [7:0] d;
      bit         pe;
      bit         odd;
      logic       pbit;
      logic       stop;
      logic [9:0] exp;
      logic [9:0] got;
      for (int i = 0; i < 12; i++) begin
         d    = 8'($urandom);
         pe   = 1'($urandom_range(0, 1));
         odd  = 1'($urandom_range(0, 1));
         // Correct parity bit, flipped about a quarter of the time.
         pbit = 1'(($countones(d) + int'(odd)) % 2);
         if ($urandom_range(0, 3) == 0) pbit = ~pbit;
         stop = ($urandom_range(0, 3) != 0);
         exp  = model_word(d, pe, odd, pbit, stop);
         wq.delete();
         send_frame(d, pe, odd, pbit, stop, -1, -1, 1'b1);
         idle_line(stop ? 8 : BIT_CLKS);
         got = (wq.size() > 0) ? wq[0] : 10'hxxx;
         n_checks++;
         if (wq.size() !== 1 || got !== exp)
            $display("FAIL random%0d: got %0d writes, word %h want 1 write, word %h", i, wq.size(), got, exp);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_frame_error();
      test_false_start();
      test_glitch();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard time limit so a stuck DUT cannot hang the run.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_uart_rxd_deser
